mem1port_arb: RTL and testbench

- Three-way request arbiter that sits directly upstream of the single-port memory model when the single-RAM build option is selected.
- Merges the core's instruction-fetch read port and its data read and data write ports onto one ready/we/addr memory port.
- Routes each one-cycle-latency read response back to the requester that issued it.
- Stops instruction fetch from starving under sustained data traffic.

---
 rtl/mem_arb_pkg.sv | 19 +
 rtl/mem_arb_prio.sv | 26 ++
 rtl/mem1port_arb.sv | 134 +++++++++++++
 tb/tb_mem1port_arb.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the single-port memory arbiter.
package mem_arb_pkg;

    // Which read requester owns the response arriving next cycle.
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_DR   = 2'd2
    } owner_e;

    // Bit positions inside the one-hot grant vector.
    localparam int unsigned GNT_IF = 0;
    localparam int unsigned GNT_DR = 1;
    localparam int unsigned GNT_DW = 2;

    // Consecutive data grants tolerated while a fetch waits.
    localparam int unsigned DEFAULT_STARVE_MAX = 4;

endpackage

// File: rtl/mem_arb_prio.sv
// Combinational priority picker: write > read > fetch, unless fetch is forced.
module mem_arb_prio
    import mem_arb_pkg::*;
(
    input  logic       i_if_req,
    input  logic       i_dr_req,
    input  logic       i_dw_req,
    input  logic       i_force_if,
    output logic [2:0] o_gnt
);

    // Pick exactly one pending requester, or none.
    always_comb begin
        o_gnt = '0;
        if (i_if_req && i_force_if) begin
            o_gnt[GNT_IF] = 1'b1;
        end else if (i_dw_req) begin
            o_gnt[GNT_DW] = 1'b1;
        end else if (i_dr_req) begin
            o_gnt[GNT_DR] = 1'b1;
        end else if (i_if_req) begin
            o_gnt[GNT_IF] = 1'b1;
        end
    end

endmodule

// File: rtl/mem1port_arb.sv
// Three-way arbiter merging fetch, data-read and data-write onto one memory port.
// Write wins over a concurrent read, so a read of the just-written word sees new data.
module mem1port_arb
    import mem_arb_pkg::*;
#(
    parameter int unsigned STARVE_MAX = DEFAULT_STARVE_MAX
)(
    input  logic        clk,
    input  logic        reset,

    input  logic        if_req,
    input  logic [29:0] if_addr,
    output logic        if_gnt,
    output logic        if_rresp,
    output logic [31:0] if_rdata,

    input  logic        dr_req,
    input  logic [29:0] dr_addr,
    output logic        dr_gnt,
    output logic        dr_rresp,
    output logic [31:0] dr_rdata,

    input  logic        dw_req,
    input  logic [29:0] dw_addr,
    input  logic [31:0] dw_wdata,
    input  logic [3:0]  dw_wstrb,
    output logic        dw_gnt,

    output logic        mem_ready,
    output logic        mem_we,
    output logic [29:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_rresp,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned CNTW = $clog2(STARVE_MAX + 1);

    owner_e          r_owner;
    owner_e          w_owner_nxt;
    logic [CNTW-1:0] r_starve_cnt;
    logic [CNTW-1:0] w_starve_nxt;
    logic            w_force_if;
    logic [2:0]      w_gnt;

    assign w_force_if = (r_starve_cnt == CNTW'(STARVE_MAX));

    // Requests are masked by reset so every grant drops the moment reset rises.
    mem_arb_prio u_prio (
        .i_if_req   (if_req & ~reset),
        .i_dr_req   (dr_req & ~reset),
        .i_dw_req   (dw_req & ~reset),
        .i_force_if (w_force_if),
        .o_gnt      (w_gnt)
    );

    assign if_gnt    = w_gnt[GNT_IF];
    assign dr_gnt    = w_gnt[GNT_DR];
    assign dw_gnt    = w_gnt[GNT_DW];
    assign mem_ready = |w_gnt;
    assign mem_we    = w_gnt[GNT_DW];

    // Route the granted requester's address, data and strobes; zero when idle.
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wstrb = '0;
        if (w_gnt[GNT_DW]) begin
            mem_addr  = dw_addr;
            mem_wdata = dw_wdata;
            mem_wstrb = dw_wstrb;
        end else if (w_gnt[GNT_DR]) begin
            mem_addr  = dr_addr;
        end else if (w_gnt[GNT_IF]) begin
            mem_addr  = if_addr;
        end
    end

    // Starvation counter next value: counts data grants while fetch waits.
    always_comb begin
        w_starve_nxt = r_starve_cnt;
        if (if_gnt || !if_req) begin
            w_starve_nxt = '0;
        end else if ((dw_gnt || dr_gnt) && !w_force_if) begin
            w_starve_nxt = r_starve_cnt + CNTW'(1);
        end
    end

    // Owner next value: who issued this cycle's read, if anyone.
    always_comb begin
        w_owner_nxt = OWN_NONE;
        if (if_gnt) begin
            w_owner_nxt = OWN_IF;
        end else if (dr_gnt) begin
            w_owner_nxt = OWN_DR;
        end
    end

    // State registers; reset discards any response still in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_owner      <= OWN_NONE;
            r_starve_cnt <= '0;
        end else begin
            r_owner      <= w_owner_nxt;
            r_starve_cnt <= w_starve_nxt;
        end
    end

    assign if_rresp = mem_rresp & (r_owner == OWN_IF);
    assign dr_rresp = mem_rresp & (r_owner == OWN_DR);
    assign if_rdata = if_rresp ? mem_rdata : '0;
    assign dr_rdata = dr_rresp ? mem_rdata : '0;

    a_gnt_onehot0: assert property (@(posedge clk) disable iff (reset) $onehot0(w_gnt));

    a_if_hold: assert property (@(posedge clk) disable iff (reset)
        (if_req && !if_gnt) |=> if_req)
        else $warning("mem1port_arb: if_req dropped before grant");

    a_dr_hold: assert property (@(posedge clk) disable iff (reset)
        (dr_req && !dr_gnt) |=> dr_req)
        else $warning("mem1port_arb: dr_req dropped before grant");

    a_dw_hold: assert property (@(posedge clk) disable iff (reset)
        (dw_req && !dw_gnt) |=> dw_req)
        else $warning("mem1port_arb: dw_req dropped before grant");

    a_orphan_rresp: assert property (@(posedge clk) disable iff (reset)
        mem_rresp |-> (r_owner != OWN_NONE))
        else $warning("mem1port_arb: read response with no owner dropped");

endmodule

// File: tb/tb_mem1port_arb.sv
// Directed bench for mem1port_arb with a behavioural one-cycle-latency memory.
module tb_mem1port_arb;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req, dr_req, dw_req;
    logic [29:0] if_addr, dr_addr, dw_addr;
    logic [31:0] dw_wdata;
    logic [3:0]  dw_wstrb;
    logic        if_gnt, if_rresp, dr_gnt, dr_rresp, dw_gnt;
    logic [31:0] if_rdata, dr_rdata;
    logic        mem_ready, mem_we;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_rresp = 1'b0;
    logic [31:0] mem_rdata = 32'h0;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    mem1port_arb #(.STARVE_MAX(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_rresp  (if_rresp),
        .if_rdata  (if_rdata),
        .dr_req    (dr_req),
        .dr_addr   (dr_addr),
        .dr_gnt    (dr_gnt),
        .dr_rresp  (dr_rresp),
        .dr_rdata  (dr_rdata),
        .dw_req    (dw_req),
        .dw_addr   (dw_addr),
        .dw_wdata  (dw_wdata),
        .dw_wstrb  (dw_wstrb),
        .dw_gnt    (dw_gnt),
        .mem_ready (mem_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_rresp (mem_rresp),
        .mem_rdata (mem_rdata)
    );

    // Memory model: unwritten words read as 0xA0 + word address.
    logic [31:0] mem_store [1024];
    logic        written   [1024];

    function automatic logic [31:0] cur_word(input logic [9:0] a);
        return written[a] ? mem_store[a] : (32'hA0 + 32'(a));
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] st);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (st[b]) r[8*b +: 8] = wd[8*b +: 8];
        end
        return r;
    endfunction

    always @(posedge clk) begin
        mem_rresp <= mem_ready && !mem_we;
        mem_rdata <= (mem_ready && !mem_we) ? cur_word(mem_addr[9:0]) : 32'h0;
        if (reset) begin
            for (int i = 0; i < 1024; i++) written[i] <= 1'b0;
        end else if (mem_ready && mem_we) begin
            mem_store[mem_addr[9:0]] <= merge(cur_word(mem_addr[9:0]), mem_wdata, mem_wstrb);
            written[mem_addr[9:0]]   <= 1'b1;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] gnts();
        return 32'({dw_gnt, dr_gnt, if_gnt});
    endfunction

    function automatic logic [31:0] rresps();
        return 32'({if_rresp, dr_rresp});
    endfunction

    task automatic set_reqs(input logic i, input logic r, input logic w);
        if_req = i;
        dr_req = r;
        dw_req = w;
    endtask

    task automatic do_reset();
        tick();
        set_reqs(0, 0, 0);
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    typedef struct {
        logic       ifq;
        logic       drq;
        logic       dwq;
        logic [2:0] gnt;   // {dw, dr, if}
        logic       ifr;
        logic       drr;
    } vec_t;

    vec_t tbl [12];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Sequence ordering matters: each starts from a known starvation count.
        tbl[0]  = '{1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 3'b001, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 1'b0, 3'b010, 1'b1, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 1'b1, 3'b100, 1'b0, 1'b1};
        tbl[4]  = '{1'b1, 1'b1, 1'b0, 3'b010, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 1'b0, 1'b1, 3'b100, 1'b0, 1'b1};
        tbl[6]  = '{1'b1, 1'b1, 1'b1, 3'b100, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, 1'b1, 1'b1, 3'b100, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 1'b1, 1'b1, 3'b001, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 1'b1, 1'b1, 3'b100, 1'b1, 1'b0};
        tbl[10] = '{1'b0, 1'b1, 1'b0, 3'b010, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b1};

        // Reset held with every request asserted.
        reset    = 1'b1;
        set_reqs(1, 1, 1);
        if_addr  = 30'h111;
        dr_addr  = 30'h222;
        dw_addr  = 30'h333;
        dw_wdata = 32'h12345678;
        dw_wstrb = 4'h5;
        for (int c = 0; c < 3; c++) begin
            tick();
            #1;
            chk($sformatf("rst%0d_gnt", c), gnts(), 32'h0);
            chk($sformatf("rst%0d_ready", c), 32'(mem_ready), 32'h0);
            chk($sformatf("rst%0d_rresp", c), rresps(), 32'h0);
            chk($sformatf("rst%0d_addr", c), 32'(mem_addr), 32'h0);
        end
        tick();
        reset = 1'b0;
        #1;
        chk("rst_release_gnt", gnts(), 32'h4);
        do_reset();

        // Priority / muxing table.
        for (int i = 0; i < 12; i++) begin
            tick();
            set_reqs(tbl[i].ifq, tbl[i].drq, tbl[i].dwq);
            #1;
            chk($sformatf("v%0d_gnt", i), gnts(), 32'(tbl[i].gnt));
            chk($sformatf("v%0d_ready", i), 32'(mem_ready), 32'(|tbl[i].gnt));
            chk($sformatf("v%0d_we", i), 32'(mem_we), 32'(tbl[i].gnt[2]));
            chk($sformatf("v%0d_addr", i), 32'(mem_addr),
                tbl[i].gnt[2] ? 32'h333 : tbl[i].gnt[1] ? 32'h222 : tbl[i].gnt[0] ? 32'h111 : 32'h0);
            chk($sformatf("v%0d_wdata", i), mem_wdata, tbl[i].gnt[2] ? 32'h12345678 : 32'h0);
            chk($sformatf("v%0d_wstrb", i), 32'(mem_wstrb), tbl[i].gnt[2] ? 32'h5 : 32'h0);
            chk($sformatf("v%0d_rresp", i), rresps(), 32'({tbl[i].ifr, tbl[i].drr}));
            chk($sformatf("v%0d_ifdata", i), if_rdata, tbl[i].ifr ? 32'h1B1 : 32'h0);
            chk($sformatf("v%0d_drdata", i), dr_rdata, tbl[i].drr ? 32'h2C2 : 32'h0);
        end
        do_reset();

        // Fetch stream at one read per cycle.
        for (int c = 0; c < 5; c++) begin
            tick();
            if_req  = (c < 3);
            if_addr = 30'h100 + 30'(c);
            #1;
            chk($sformatf("fs%0d_gnt", c), gnts(), (c < 3) ? 32'h1 : 32'h0);
            chk($sformatf("fs%0d_rresp", c), rresps(), (c >= 1 && c <= 3) ? 32'h2 : 32'h0);
            chk($sformatf("fs%0d_data", c), if_rdata,
                (c >= 1 && c <= 3) ? (32'h1A0 + 32'(c - 1)) : 32'h0);
        end

        // Concurrent write and read to the same word.
        tick();
        set_reqs(0, 1, 1);
        dr_addr  = 30'h40;
        dw_addr  = 30'h40;
        dw_wdata = 32'hDEADBEEF;
        dw_wstrb = 4'hF;
        #1;
        chk("wr_first_gnt", gnts(), 32'h4);
        chk("wr_first_we", 32'(mem_we), 32'h1);
        tick();
        dw_req = 1'b0;
        #1;
        chk("rd_second_gnt", gnts(), 32'h2);
        chk("rd_second_addr", 32'(mem_addr), 32'h40);
        tick();
        dr_req = 1'b0;
        #1;
        chk("raw_rresp", rresps(), 32'h1);
        chk("raw_data", dr_rdata, 32'hDEADBEEF);

        // Starvation: sustained reads with a waiting fetch.
        if_addr = 30'h111;
        dr_addr = 30'h222;
        for (int c = 0; c < 10; c++) begin
            tick();
            set_reqs(1, 1, 0);
            #1;
            chk($sformatf("sv%0d_gnt", c), gnts(), (c == 4 || c == 9) ? 32'h1 : 32'h2);
            if (c > 0) begin
                chk($sformatf("sv%0d_rresp", c), rresps(), (c == 5) ? 32'h2 : 32'h1);
            end
        end
        tick();
        set_reqs(0, 0, 0);

        // Routing interleave: data read then fetch.
        tick();
        set_reqs(0, 1, 0);
        #1;
        chk("il0_gnt", gnts(), 32'h2);
        tick();
        set_reqs(1, 0, 0);
        #1;
        chk("il1_gnt", gnts(), 32'h1);
        chk("il1_rresp", rresps(), 32'h1);
        chk("il1_drdata", dr_rdata, 32'h2C2);
        tick();
        set_reqs(0, 0, 0);
        #1;
        chk("il2_rresp", rresps(), 32'h2);
        chk("il2_ifdata", if_rdata, 32'h1B1);
        tick();
        #1;
        chk("il3_rresp", rresps(), 32'h0);

        // Reset while a fetch response is in flight.
        tick();
        if_addr = 30'h100;
        set_reqs(1, 0, 0);
        #1;
        chk("mf_gnt", gnts(), 32'h1);
        tick();
        reset = 1'b1;
        #1;
        chk("mf_rst_rresp", rresps(), 32'h0);
        chk("mf_rst_gnt", gnts(), 32'h0);
        chk("mf_rst_ready", 32'(mem_ready), 32'h0);
        tick();
        reset = 1'b0;
        #1;
        chk("mf_rel_rresp", rresps(), 32'h0);
        chk("mf_rel_gnt", gnts(), 32'h1);
        tick();
        set_reqs(0, 0, 0);
        #1;
        chk("mf_after_rresp", rresps(), 32'h2);
        chk("mf_after_data", if_rdata, 32'h1A0);

        tick();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
